// File: rtl/lvt_memory_master.sv
// Per-port command FSMs that turn valid/ready read/write commands into LVT memory port accesses.
// Optional macro LVT_MASTER_WR_CONFLICT_EN serializes same-address writes (lowest port index wins).
module lvt_memory_master #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int PORTS = 4,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid_i [PORTS],
    output logic             cmd_ready_o [PORTS],
    input  logic             cmd_we_i    [PORTS],
    input  logic [AW-1:0]    cmd_addr_i  [PORTS],
    input  logic [WIDTH-1:0] cmd_data_i  [PORTS],
    output logic             rsp_valid_o [PORTS],
    input  logic             rsp_ready_i [PORTS],
    output logic [WIDTH-1:0] rsp_data_o  [PORTS],
    output logic [AW-1:0]    mem_addr_o  [PORTS],
    output logic             mem_en_o    [PORTS],
    output logic [WIDTH-1:0] mem_d_o     [PORTS],
    input  logic [WIDTH-1:0] mem_q_i     [PORTS]
);

    typedef enum logic [2:0] {IDLE, WR_ISSUE, RD_ISSUE, RD_CAPT, RSP} state_e;

    state_e           st_q    [PORTS];
    state_e           st_d    [PORTS];
    logic [AW-1:0]    addr_q  [PORTS];
    logic [AW-1:0]    addr_d  [PORTS];
    logic [WIDTH-1:0] wdata_q [PORTS];
    logic [WIDTH-1:0] wdata_d [PORTS];
    logic [WIDTH-1:0] rdata_q [PORTS];
    logic [WIDTH-1:0] rdata_d [PORTS];
    logic             ready_q [PORTS];
    logic             ready_d [PORTS];
    logic             rvld_q  [PORTS];
    logic             rvld_d  [PORTS];
    logic             en_q    [PORTS];
    logic             en_d    [PORTS];

    always_comb begin
        for (int p = 0; p < PORTS; p++) begin
            st_d[p]    = st_q[p];
            addr_d[p]  = addr_q[p];
            wdata_d[p] = wdata_q[p];
            rdata_d[p] = rdata_q[p];
            unique case (st_q[p])
                IDLE: begin
                    if (cmd_valid_i[p] && ready_q[p]) begin
                        addr_d[p]  = cmd_addr_i[p];
                        wdata_d[p] = cmd_data_i[p];
                        st_d[p]    = cmd_we_i[p] ? WR_ISSUE : RD_ISSUE;
                    end
                end
                // en_q high means this cycle's write is the one reaching memory
                WR_ISSUE: if (en_q[p]) st_d[p] = IDLE;
                RD_ISSUE: st_d[p] = RD_CAPT;
                RD_CAPT: begin
                    rdata_d[p] = mem_q_i[p];
                    st_d[p]    = RSP;
                end
                RSP:      if (rsp_ready_i[p]) st_d[p] = IDLE;
                default:  st_d[p] = IDLE;
            endcase
        end

        // Outputs are registered, so the grant is decided on next-state values.
        for (int p = 0; p < PORTS; p++) begin
            ready_d[p] = (st_d[p] == IDLE);
            rvld_d[p]  = (st_d[p] == RSP);
            en_d[p]    = (st_d[p] == WR_ISSUE);
        end
`ifdef LVT_MASTER_WR_CONFLICT_EN
        for (int j = 0; j < PORTS; j++) begin
            for (int i = 0; i < PORTS; i++) begin
                if (i < j && st_d[i] == WR_ISSUE && st_d[j] == WR_ISSUE &&
                    addr_d[i] == addr_d[j])
                    en_d[j] = 1'b0;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < PORTS; p++) begin
                st_q[p]    <= IDLE;
                addr_q[p]  <= '0;
                wdata_q[p] <= '0;
                rdata_q[p] <= '0;
                ready_q[p] <= 1'b0;
                rvld_q[p]  <= 1'b0;
                en_q[p]    <= 1'b0;
            end
        end else begin
            for (int p = 0; p < PORTS; p++) begin
                st_q[p]    <= st_d[p];
                addr_q[p]  <= addr_d[p];
                wdata_q[p] <= wdata_d[p];
                rdata_q[p] <= rdata_d[p];
                ready_q[p] <= ready_d[p];
                rvld_q[p]  <= rvld_d[p];
                en_q[p]    <= en_d[p];
            end
        end
    end

    assign cmd_ready_o = ready_q;
    assign rsp_valid_o = rvld_q;
    assign rsp_data_o  = rdata_q;
    assign mem_addr_o  = addr_q;
    assign mem_en_o    = en_q;
    assign mem_d_o     = wdata_q;

endmodule

// File: doc/lvt_memory_master.md
LVT_MEMORY_MASTER -- requirements
Module: lvt_memory_master

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8: memory words; address width is $clog2(DEPTH).
REQ-003 The block SHALL have parameter PORTS, default 4: number of independent command/memory ports.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 cmd_valid  input  [PORTS-1:0] unpacked  per-port command valid.
REQ-007 cmd_ready  output  [PORTS-1:0] unpacked  per-port command accept.
REQ-008 cmd_we  input  [PORTS-1:0] unpacked  1 = write, 0 = read.
REQ-009 cmd_addr  input  $clog2(DEPTH) x PORTS unpacked  command address.
REQ-010 cmd_data  input  WIDTH x PORTS unpacked  write data.
REQ-011 rsp_valid  output  [PORTS-1:0] unpacked  read data valid.
REQ-012 rsp_ready  input  [PORTS-1:0] unpacked  read data accept.
REQ-013 rsp_data  output  WIDTH x PORTS unpacked  read data.
REQ-014 mem_addr, mem_en, mem_d  output  same shapes as lvt_memory addr/en/d  drive lvt_memory port p.
REQ-015 mem_q  input  WIDTH x PORTS unpacked  lvt_memory q; valid one cycle after mem_addr is sampled.

Function
REQ-016 Each port SHALL run an independent FSM with states IDLE, WR_ISSUE, RD_ISSUE, RD_CAPT, RSP.
REQ-017 cmd_ready[p] SHALL be 1 only in IDLE; a command is accepted on an edge where cmd_valid[p] && cmd_ready[p].
REQ-018 On accept, cmd_addr/cmd_data SHALL be registered; FSM goes to WR_ISSUE if cmd_we else RD_ISSUE.
REQ-019 mem_addr[p] and mem_d[p] SHALL be driven only from the registered values and hold when not updated.
REQ-020 In WR_ISSUE, mem_en[p] SHALL be 1 for exactly one cycle (when granted) then FSM returns to IDLE; mem_en[p] SHALL be 0 in every other state.
REQ-021 RD_ISSUE SHALL last one cycle; RD_CAPT SHALL last one cycle and register mem_q[p] into rsp_data[p] at its closing edge; FSM then enters RSP.
REQ-022 In RSP, rsp_valid[p] SHALL be 1 with rsp_data[p] stable until rsp_ready[p] is sampled 1; FSM then returns to IDLE.
REQ-023 Read latency SHALL be 3 cycles from accept edge to first rsp_valid cycle; write occupies 2 cycles (accept to next ready).
REQ-024 rsp_ready[p] asserted outside RSP SHALL be ignored; cmd_valid[p] outside IDLE SHALL be ignored (no buffering).
REQ-025 Reads and writes on different ports SHALL proceed concurrently with no cross-port interaction except REQ-030.

Reset
REQ-026 While rst_n is 0, all FSMs SHALL be IDLE immediately (asynchronously).
REQ-027 Reset values: cmd_ready all 1 only after rst_n deasserts (0 while in reset), rsp_valid 0, rsp_data 0, mem_en 0, mem_addr 0, mem_d 0.
REQ-028 Reset mid-operation SHALL abort in-flight commands; a pending write not yet issued SHALL NOT reach memory; an unconsumed read response SHALL be dropped.

Configuration
REQ-029 Macro LVT_MASTER_WR_CONFLICT_EN SHALL select same-address write arbitration.
REQ-030 With LVT_MASTER_WR_CONFLICT_EN defined: if ports i<j are both in WR_ISSUE with equal addresses, port j SHALL hold mem_en[j]=0 and stay in WR_ISSUE until no lower port conflicts; lowest index wins.
REQ-031 Without LVT_MASTER_WR_CONFLICT_EN: every WR_ISSUE SHALL assert mem_en immediately; same-address concurrent writes are passed through and memory result is unspecified.

Verification
REQ-032 Reset then idle -> cmd_ready all 1, mem_en all 0, rsp_valid all 0.
REQ-033 Port 0 write addr 5 data 42, then port 1 read addr 5 after write completes -> rsp_valid[1] 3 cycles after read accept, rsp_data[1]=42.
REQ-034 Read port 2 addr 3 with rsp_ready[2]=0 for 4 cycles -> rsp_valid[2] held, rsp_data[2] stable, cmd_ready[2]=0 until handshake.
REQ-035 Ports 0 and 3 write addr 7 (data 1, 2) same cycle, macro defined -> port 0 issues first, port 3 one cycle later; later read of addr 7 returns 2.
REQ-036 Same stimulus, macro undefined -> mem_en[0] and mem_en[3] both 1 in the same cycle.
REQ-037 rst_n pulsed low during port 1 RD_CAPT -> rsp_valid[1] stays 0, FSM IDLE, cmd_ready[1]=1 the cycle after rst_n rises.
